// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ==========================================================================
// alu_arbiter_if : request/response/ALU bundle shared by the ALU arbiter
// Revision       : 1.0
// ==========================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 32
) ();

  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_err;

  logic [WIDTH-1:0] alu_srca;
  logic [WIDTH-1:0] alu_srcb;
  logic             alu_ainv;
  logic             alu_binv;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    input  rsp0_ready, rsp1_ready,
    output alu_srca, alu_srcb, alu_ainv, alu_binv, alu_sel,
    input  alu_result, alu_zero
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    output rsp0_ready, rsp1_ready,
    input  alu_srca, alu_srcb, alu_ainv, alu_binv, alu_sel,
    output alu_result, alu_zero
  );

endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ==========================================================================
// alu_arbiter : two-port round-robin sequencer for a shared RISC-V ALU
// Revision    : 1.0
// ==========================================================================
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave io_bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_exec = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_gnt;
  logic             r_last_grant;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;

  logic             w_any_req;
  logic             w_pick1;
  logic             w_op_legal;
  logic             w_rsp_ready;

  function automatic logic f_op_legal(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: f_op_legal = 1'b1;
      default:                             f_op_legal = 1'b0;
    endcase
  endfunction

  assign w_any_req   = io_bus.req0_valid | io_bus.req1_valid;
  // Port 1 wins when it is alone, or on a tie when port 0 was served last.
  assign w_pick1     = io_bus.req1_valid & (~io_bus.req0_valid | ~r_last_grant);
  assign w_op_legal  = f_op_legal(r_op);
  assign w_rsp_ready = r_gnt ? io_bus.rsp1_ready : io_bus.rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_any_req) w_state_nxt = c_st_exec;
      c_st_exec: w_state_nxt = c_st_resp;
      c_st_resp: if (w_rsp_ready) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    io_bus.req0_ready = 1'b0;
    io_bus.req1_ready = 1'b0;
    io_bus.rsp0_valid = 1'b0;
    io_bus.rsp1_valid = 1'b0;
    // Gating with rst_n keeps ready low while reset is held, even with valid up.
    if (rst_n && (r_state == c_st_idle)) begin
      io_bus.req0_ready = io_bus.req0_valid & ~w_pick1;
      io_bus.req1_ready = w_pick1;
    end
    if (r_state == c_st_resp) begin
      io_bus.rsp0_valid = ~r_gnt;
      io_bus.rsp1_valid = r_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_op         <= 4'd0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_any_req) begin
            r_gnt <= w_pick1;
            r_op  <= w_pick1 ? io_bus.req1_op : io_bus.req0_op;
            r_a   <= w_pick1 ? io_bus.req1_a  : io_bus.req0_a;
            r_b   <= w_pick1 ? io_bus.req1_b  : io_bus.req0_b;
          end
        end
        c_st_exec: begin
          r_result <= w_op_legal ? io_bus.alu_result : '0;
          r_zero   <= w_op_legal ? io_bus.alu_zero : 1'b1;
          r_err    <= ~w_op_legal;
        end
        c_st_resp: begin
          if (w_rsp_ready) r_last_grant <= r_gnt;
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.alu_srca   = r_a;
  assign io_bus.alu_srcb   = r_b;
  assign io_bus.alu_ainv   = r_op[3];
  assign io_bus.alu_binv   = r_op[2];
  assign io_bus.alu_sel    = r_op[1:0];
  assign io_bus.rsp_result = r_result;
  assign io_bus.rsp_zero   = r_zero;
  assign io_bus.rsp_err    = r_err;

  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(io_bus.rsp0_valid && io_bus.rsp1_valid));

  a_req_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(io_bus.req0_ready && io_bus.req1_ready));

  a_rsp0_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (io_bus.rsp0_valid && !io_bus.rsp0_ready) |=>
      (io_bus.rsp0_valid && $stable(r_result) && $stable(r_zero) && $stable(r_err)));

  a_rsp1_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (io_bus.rsp1_valid && !io_bus.rsp1_ready) |=>
      (io_bus.rsp1_valid && $stable(r_result) && $stable(r_zero) && $stable(r_err)));

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_alu_arbiter : scoreboard bench with a reference ALU-op model
// Revision       : 1.0
// ==========================================================================
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  // Combinational ALU the arbiter drives: invert, then AND/OR/ADD/SLT.
  logic [WIDTH-1:0] alu_a_eff, alu_b_eff;
  logic [WIDTH:0]   alu_sum;
  always_comb begin
    alu_a_eff = bus.alu_ainv ? ~bus.alu_srca : bus.alu_srca;
    alu_b_eff = bus.alu_binv ? ~bus.alu_srcb : bus.alu_srcb;
    alu_sum   = {1'b0, alu_a_eff} + {1'b0, alu_b_eff} + {{WIDTH{1'b0}}, bus.alu_binv};
    case (bus.alu_sel)
      2'd0:    bus.alu_result = alu_a_eff & alu_b_eff;
      2'd1:    bus.alu_result = alu_a_eff | alu_b_eff;
      2'd2:    bus.alu_result = alu_sum[WIDTH-1:0];
      default: bus.alu_result = {{(WIDTH-1){1'b0}}, ~alu_sum[WIDTH]};
    endcase
    bus.alu_zero = (bus.alu_result == '0);
  end

  typedef struct {
    logic        port;
    logic [31:0] result;
    logic        zero;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   busy = 1'b0;
  bit   m_last = 1'b1;
  bit   win;
  bit   rnd_mode = 1'b0;
  int   stall_left = 0;
  bit   have_cur = 1'b0;
  bit   done_prev = 1'b0;
  bit   rsp_r;
  exp_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic port, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b, input int acc);
    exp_t e;
    e.port = port;
    e.acc  = acc;
    e.err  = 1'b0;
    case (op)
      4'd0:    e.result = a & b;
      4'd1:    e.result = a | b;
      4'd2:    e.result = a + b;
      4'd6:    e.result = a - b;
      4'd7:    e.result = (a < b) ? 32'd1 : 32'd0;
      4'd12:   e.result = ~(a | b);
      default: begin e.result = 32'd0; e.err = 1'b1; end
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    check({tag, "_rsp_result"}, bus.rsp_result, 32'd0);
    check({tag, "_rsp_flags"}, 32'({bus.rsp_zero, bus.rsp_err}), 32'd0);
    check({tag, "_alu_srca"}, bus.alu_srca, 32'd0);
    check({tag, "_alu_srcb"}, bus.alu_srcb, 32'd0);
    check({tag, "_alu_ctl"}, 32'({bus.alu_ainv, bus.alu_binv, bus.alu_sel}), 32'd0);
    check({tag, "_req_ready"}, 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
  endtask

  // Arbitration model: one transaction in flight, round-robin on ties.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        busy   = 1'b0;
        m_last = 1'b1;
      end else if (busy) begin
        check("req_ready_busy", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        if (bus.rsp0_valid && bus.rsp0_ready) begin
          busy = 1'b0; m_last = 1'b0;
        end else if (bus.rsp1_valid && bus.rsp1_ready) begin
          busy = 1'b0; m_last = 1'b1;
        end
      end else if (bus.req0_valid || bus.req1_valid) begin
        win = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
        check("grant", 32'({bus.req1_ready, bus.req0_ready}), win ? 32'd2 : 32'd1);
        if (win) sb.push_back(model(1'b1, bus.req1_op, bus.req1_a, bus.req1_b, cyc));
        else     sb.push_back(model(1'b0, bus.req0_op, bus.req0_a, bus.req0_b, cyc));
        busy = 1'b1;
      end else begin
        check("req_ready_idle", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      end
    end
  end

  // Response monitor: pops on first presentation, rechecks every stalled cycle.
  initial begin
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_cur = 1'b0; done_prev = 1'b0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
      end else begin
        if (done_prev)
          check("rsp_valid_after_done", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        done_prev = 1'b0;
        rsp_r = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (bus.rsp0_valid || bus.rsp1_valid) begin
          if (!have_cur) begin
            if (sb.size() == 0) begin
              check("rsp_unexpected", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
            end else begin
              cur = sb.pop_front();
              have_cur = 1'b1;
              check("rsp_latency", 32'(cyc), 32'(cur.acc + 2));
            end
          end
          if (have_cur) begin
            check("rsp_port", 32'({bus.rsp1_valid, bus.rsp0_valid}), cur.port ? 32'd2 : 32'd1);
            check("rsp_result", bus.rsp_result, cur.result);
            check("rsp_zero", 32'(bus.rsp_zero), 32'(cur.zero));
            check("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
            if (stall_left > 0) begin
              rsp_r = 1'b0;
              stall_left--;
            end
            if (rsp_r) begin
              have_cur = 1'b0; done_prev = 1'b1;
            end
          end
        end
        bus.rsp0_ready = rsp_r;
        bus.rsp1_ready = rsp_r;
      end
    end
  end

  task automatic do_req(input bit p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit acc = 1'b0;
    @(negedge clk);
    if (p) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    for (int n = 0; n < 400 && !acc; n++) begin
      #1;
      acc = p ? bus.req1_ready : bus.req0_ready;
      @(negedge clk);
    end
    if (p) bus.req1_valid = 1'b0;
    else   bus.req0_valid = 1'b0;
    if (!acc) check("req_accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [3:0] rand_op();
    case ($urandom_range(0, 7))
      0:       rand_op = 4'd0;
      1:       rand_op = 4'd1;
      2:       rand_op = 4'd2;
      3:       rand_op = 4'd6;
      4:       rand_op = 4'd7;
      5:       rand_op = 4'd12;
      default: rand_op = 4'($urandom_range(0, 15));
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       rand_operand = 32'($urandom_range(0, 15));
      1:       rand_operand = 32'hFFFF_FFFF;
      default: rand_operand = $urandom;
    endcase
  endfunction

  task automatic port_loop(input bit p);
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = rand_operand();
      b = ($urandom_range(0, 3) == 0) ? a : rand_operand();
      do_req(p, rand_op(), a, b);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = 4'd0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 4'd0; bus.req1_a = '0; bus.req1_b = '0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    bus.req0_valid = 1'b0;
    #1;
    rst_n = 1'b1;

    fork
      do_req(1'b0, 4'd6, 32'd9, 32'd9);
      do_req(1'b1, 4'd1, 32'hF0, 32'h0F);
    join
    drain();

    do_req(1'b0, 4'd2, 32'd5, 32'd7);
    drain();

    fork
      do_req(1'b0, 4'd2, 32'h10, 32'h20);
      do_req(1'b1, 4'd6, 32'h20, 32'h10);
    join
    drain();

    do_req(1'b1, 4'd3, 32'd1, 32'd1);
    drain();

    stall_left = 4;
    do_req(1'b0, 4'd7, 32'd3, 32'hFFFF_FFFF);
    drain();

    do_req(1'b0, 4'd0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_exec");
    sb.delete();
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    do_req(1'b1, 4'd12, 32'h0000_FFFF, 32'h00FF_0000);
    drain();

    rnd_mode = 1'b1;
    fork
      port_loop(1'b0);
      port_loop(1'b1);
    join
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
